// File: rtl/knn_pkg.sv
// Shared definitions for the k-NN datapath (training_data_feeder, knn_system).
// Holds the default geometry of a training vector and the feeder FSM encoding.
package knn_pkg;

    // Default geometry of one training entry.
    localparam int unsigned KNN_W            = 16;
    localparam int unsigned KNN_MAX_ELEMENTS = 32;
    localparam int unsigned KNN_TYPE_W       = 3;
    localparam int unsigned KNN_L            = 6;

    // Feeder FSM encoding.
    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StRead      = 2'd1,
        StPresent   = 2'd2,
        StExhausted = 2'd3
    } feeder_state_e;

    // Width of one stored entry: feature vector plus its class label.
    function automatic int unsigned entry_width(input int unsigned w,
                                                input int unsigned n,
                                                input int unsigned t);
        return w * n + t;
    endfunction

endpackage

// File: rtl/training_mem.sv
// Training-set storage: NV entries of {label, vector}, one synchronous write
// port and one registered read port. A read and write to the same address in
// the same cycle return the old contents (read-first). Contents have no reset.
module training_mem
    import knn_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = KNN_L,
    parameter int unsigned DW         = entry_width(KNN_W, KNN_MAX_ELEMENTS, KNN_TYPE_W)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DW-1:0]         rd_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DW-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; sees the pre-write value on a same-address collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/training_data_feeder.sv
// Serves stored training vectors one at a time to a k-NN consumer.
// A request taken in IDLE reads memory, waits one cycle (READ), then PRESENT
// latches the entry onto training_data and pulses read_done the next cycle.
// Also holds the query vector captured via input_load.
// Optional feature: define KNN_FEEDER_WRAP_EN to wrap from entry NV-1 back to
// entry 0 instead of stopping in EXHAUSTED.
module training_data_feeder
    import knn_pkg::*;
#(
    parameter int unsigned W            = KNN_W,
    parameter int unsigned MAX_ELEMENTS = KNN_MAX_ELEMENTS,
    parameter int unsigned TYPE_W       = KNN_TYPE_W,
    parameter int unsigned L            = KNN_L
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    input  logic [L-1:0]              load_addr,
    input  logic [W*MAX_ELEMENTS-1:0] load_data,
    input  logic [TYPE_W-1:0]         load_type,
    input  logic                      input_load,
    input  logic [W*MAX_ELEMENTS-1:0] input_vec,
    input  logic                      rewind,
    input  logic                      data_request,
    output logic [W*MAX_ELEMENTS-1:0] training_data,
    output logic [TYPE_W-1:0]         training_data_type,
    output logic [W*MAX_ELEMENTS-1:0] input_data,
    output logic                      read_done,
    output logic [L-1:0]              vector_index,
    output logic                      set_done,
    output logic                      exhausted,
    output logic                      busy
);

    localparam int unsigned VW = W * MAX_ELEMENTS;
    localparam int unsigned DW = entry_width(W, MAX_ELEMENTS, TYPE_W);
    localparam logic [L-1:0] LAST_IDX = '1;

    feeder_state_e       state_q, state_d;
    logic [L-1:0]        index_q, index_d;
    logic [VW-1:0]       train_data_q;
    logic [TYPE_W-1:0]   train_type_q;
    logic [VW-1:0]       input_data_q;
    logic                read_done_q;
    logic                set_done_q;

    logic                mem_rd_en;
    logic [DW-1:0]       mem_rd_data;
    logic                present_fire;

    training_mem #(
        .DEPTH_LOG2 (L),
        .DW         (DW)
    ) u_training_mem (
        .clk     (clk),
        .wr_en   (load_valid),
        .wr_addr (load_addr),
        .wr_data ({load_type, load_data}),
        .rd_en   (mem_rd_en),
        .rd_addr (index_q),
        .rd_data (mem_rd_data)
    );

    // Next-state logic; rewind overrides everything and cancels any fetch.
    always_comb begin
        state_d      = state_q;
        mem_rd_en    = 1'b0;
        present_fire = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_request) begin
                    mem_rd_en = 1'b1;
                    state_d   = StRead;
                end
            end
            StRead: begin
                state_d = StPresent;
            end
            StPresent: begin
                present_fire = 1'b1;
`ifdef KNN_FEEDER_WRAP_EN
                state_d = StIdle;
`else
                state_d = (index_q == LAST_IDX) ? StExhausted : StIdle;
`endif
            end
            StExhausted: begin
                state_d = StExhausted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (rewind) begin
            state_d      = StIdle;
            mem_rd_en    = 1'b0;
            present_fire = 1'b0;
        end
    end

    // Entry pointer: advances once per presented entry, wrapping modulo NV.
    always_comb begin
        index_d = index_q;
        if (rewind) begin
            index_d = '0;
        end else if (present_fire) begin
            index_d = index_q + 1'b1;
        end
    end

    // FSM state and entry pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // Presented entry and completion pulses; output regs hold until next PRESENT.
    always_ff @(posedge clk) begin
        if (rst) begin
            train_data_q <= '0;
            train_type_q <= '0;
            read_done_q  <= 1'b0;
            set_done_q   <= 1'b0;
        end else begin
            read_done_q <= present_fire;
            set_done_q  <= present_fire && (index_q == LAST_IDX);
            if (present_fire) begin
                train_data_q <= mem_rd_data[VW-1:0];
                train_type_q <= mem_rd_data[DW-1:VW];
            end
        end
    end

    // Query register, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            input_data_q <= '0;
        end else if (input_load) begin
            input_data_q <= input_vec;
        end
    end

    assign training_data      = train_data_q;
    assign training_data_type = train_type_q;
    assign input_data         = input_data_q;
    assign read_done          = read_done_q;
    assign set_done           = set_done_q;
    assign vector_index       = index_q;
    assign exhausted          = (state_q == StExhausted);
    assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_training_data_feeder.sv
// Self-checking bench for training_data_feeder. Expected values come from a
// behavioural model: an array mirroring memory plus a next-entry counter and
// an exhausted flag. Honours KNN_FEEDER_WRAP_EN when defined.
module tb_training_data_feeder;
    import knn_pkg::*;

    localparam int W      = 16;
    localparam int ME     = 32;
    localparam int TYPE_W = 3;
    localparam int L      = 6;
    localparam int NV     = 1 << L;
    localparam int VW     = W * ME;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_valid = 1'b0;
    logic [L-1:0]      load_addr = '0;
    logic [VW-1:0]     load_data = '0;
    logic [TYPE_W-1:0] load_type = '0;
    logic              input_load = 1'b0;
    logic [VW-1:0]     input_vec = '0;
    logic              rewind = 1'b0;
    logic              data_request = 1'b0;
    logic [VW-1:0]     training_data;
    logic [TYPE_W-1:0] training_data_type;
    logic [VW-1:0]     input_data;
    logic              read_done;
    logic [L-1:0]      vector_index;
    logic              set_done;
    logic              exhausted;
    logic              busy;

    training_data_feeder #(
        .W            (W),
        .MAX_ELEMENTS (ME),
        .TYPE_W       (TYPE_W),
        .L            (L)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .load_valid         (load_valid),
        .load_addr          (load_addr),
        .load_data          (load_data),
        .load_type          (load_type),
        .input_load         (input_load),
        .input_vec          (input_vec),
        .rewind             (rewind),
        .data_request       (data_request),
        .training_data      (training_data),
        .training_data_type (training_data_type),
        .input_data         (input_data),
        .read_done          (read_done),
        .vector_index       (vector_index),
        .set_done           (set_done),
        .exhausted          (exhausted),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model.
    logic [VW-1:0]     m_data [NV];
    logic [TYPE_W-1:0] m_type [NV];
    int                m_idx = 0;
    bit                m_exh = 1'b0;
    logic [VW-1:0]     m_query = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic model_serve();
        if (m_idx == NV - 1) begin
            m_idx = 0;
`ifndef KNN_FEEDER_WRAP_EN
            m_exh = 1'b1;
`endif
        end else begin
            m_idx++;
        end
    endtask

    task automatic write_entry(input int addr, input logic [VW-1:0] d, input logic [TYPE_W-1:0] t);
        load_valid = 1'b1;
        load_addr  = L'(addr);
        load_data  = d;
        load_type  = t;
        tick();
        load_valid = 1'b0;
        m_data[addr] = d;
        m_type[addr] = t;
    endtask

    task automatic do_rewind();
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        m_idx = 0;
        m_exh = 1'b0;
    endtask

    // One single-cycle request; read_done is due exactly two edges after the sample edge.
    task automatic fetch_check(input string name);
        logic              exp_rd;
        logic [VW-1:0]     exp_d;
        logic [TYPE_W-1:0] exp_t;
        logic              exp_set;
        exp_rd  = !m_exh;
        exp_d   = m_data[m_idx];
        exp_t   = m_type[m_idx];
        exp_set = (m_idx == NV - 1);
        data_request = 1'b1;
        tick();
        data_request = 1'b0;
        tick();
        checks++;
        if (read_done !== 1'b0) begin
            errors++;
            $display("FAIL %s early_read_done: got %b want 0", name, read_done);
        end
        tick();
        checks++;
        if (read_done !== exp_rd) begin
            errors++;
            $display("FAIL %s read_done: got %b want %b", name, read_done, exp_rd);
        end
        if (exp_rd) begin
            checks++;
            if (training_data !== exp_d || training_data_type !== exp_t) begin
                errors++;
                $display("FAIL %s entry: got type %0d data %h want type %0d data %h",
                         name, training_data_type, training_data[63:0], exp_t, exp_d[63:0]);
            end
            checks++;
            if (set_done !== exp_set) begin
                errors++;
                $display("FAIL %s set_done: got %b want %b", name, set_done, exp_set);
            end
            model_serve();
            checks++;
            if (vector_index !== L'(m_idx) || exhausted !== m_exh) begin
                errors++;
                $display("FAIL %s index/exhausted: got %0d/%b want %0d/%b",
                         name, vector_index, exhausted, m_idx, m_exh);
            end
        end else begin
            checks++;
            if (exhausted !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s exhausted_hold: got exh %b busy %b want 1 1",
                         name, exhausted, busy);
            end
        end
        tick();
        checks++;
        if (read_done !== 1'b0 || (exp_rd && training_data !== exp_d)) begin
            errors++;
            $display("FAIL %s pulse_hold: got read_done %b want 0 with data held", name, read_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({read_done, set_done, exhausted, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {read_done, set_done, exhausted, busy});
        end
        checks++;
        if (vector_index !== '0) begin
            errors++;
            $display("FAIL reset_index: got %0d want 0", vector_index);
        end
        checks++;
        if (training_data !== '0 || training_data_type !== '0 || input_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got type %0d data %h query %h want zeros",
                     training_data_type, training_data[63:0], input_data[63:0]);
        end
        m_idx = 0;
        m_exh = 1'b0;
    endtask

    task automatic test_fill();
        for (int a = 0; a < NV; a++) write_entry(a, rand_vec(), TYPE_W'($urandom_range(0, 7)));
    endtask

    task automatic test_entry5();
        logic [VW-1:0] d;
        for (int i = 0; i < VW / 8; i++) d[i*8 +: 8] = 8'h0A;
        write_entry(5, d, 3'd3);
        do_rewind();
        for (int i = 0; i < 6; i++) fetch_check($sformatf("entry5_req%0d", i));
        checks++;
        if (training_data_type !== 3'd3 || training_data !== d || vector_index !== 6) begin
            errors++;
            $display("FAIL entry5_final: got type %0d idx %0d want type 3 idx 6",
                     training_data_type, vector_index);
        end
    endtask

    // Request held high: one entry every third cycle, in index order.
    task automatic test_back_to_back();
        int reads = 0;
        int exp_reads;
        logic exp_rd;
`ifdef KNN_FEEDER_WRAP_EN
        exp_reads = NV + 2;
`else
        exp_reads = NV;
`endif
        do_rewind();
        data_request = 1'b1;
        for (int c = 1; c <= 3 * (NV + 2); c++) begin
            tick();
            exp_rd = (c % 3 == 0) && !m_exh;
            checks++;
            if (read_done !== exp_rd) begin
                errors++;
                $display("FAIL b2b_read_done cycle %0d: got %b want %b", c, read_done, exp_rd);
            end
            if (exp_rd) begin
                reads++;
                checks++;
                if (training_data !== m_data[m_idx] || training_data_type !== m_type[m_idx]
                    || set_done !== (m_idx == NV - 1)) begin
                    errors++;
                    $display("FAIL b2b_entry %0d: got type %0d set %b want type %0d set %b",
                             m_idx, training_data_type, set_done, m_type[m_idx], m_idx == NV - 1);
                end
                model_serve();
            end else if (set_done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL b2b_stray_set_done cycle %0d: got 1 want 0", c);
            end
        end
        data_request = 1'b0;
        checks++;
        if (reads != exp_reads || exhausted !== m_exh || vector_index !== L'(m_idx)) begin
            errors++;
            $display("FAIL b2b_end: got reads %0d exh %b idx %0d want %0d %b %0d",
                     reads, exhausted, vector_index, exp_reads, m_exh, m_idx);
        end
`ifndef KNN_FEEDER_WRAP_EN
        fetch_check("exhausted_request");
        do_rewind();
        checks++;
        if (exhausted !== 1'b0 || busy !== 1'b0 || vector_index !== '0) begin
            errors++;
            $display("FAIL rewind_clears_exhausted: got exh %b busy %b idx %0d want 0 0 0",
                     exhausted, busy, vector_index);
        end
`endif
    endtask

    task automatic test_rewind_in_read();
        do_rewind();
        fetch_check("pre_rewind_a");
        fetch_check("pre_rewind_b");
        data_request = 1'b1;
        tick();
        data_request = 1'b0;
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        m_idx = 0;
        m_exh = 1'b0;
        checks++;
        if (read_done !== 1'b0 || vector_index !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rewind_in_read: got rd %b idx %0d busy %b want 0 0 0",
                     read_done, vector_index, busy);
        end
        tick();
        checks++;
        if (read_done !== 1'b0) begin
            errors++;
            $display("FAIL rewind_in_read_late: got read_done %b want 0", read_done);
        end
        // Rewind wins over a simultaneous request.
        rewind = 1'b1;
        data_request = 1'b1;
        tick();
        rewind = 1'b0;
        data_request = 1'b0;
        tick();
        tick();
        checks++;
        if (read_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rewind_priority: got rd %b busy %b want 0 0", read_done, busy);
        end
        fetch_check("after_rewind");
    endtask

    task automatic test_load_collision();
        logic [VW-1:0]     old_d, new_d;
        logic [TYPE_W-1:0] old_t, new_t;
        do_rewind();
        fetch_check("coll_pre0");
        fetch_check("coll_pre1");
        old_d = m_data[2];
        old_t = m_type[2];
        new_d = ~old_d;
        new_t = ~old_t;
        data_request = 1'b1;
        load_valid   = 1'b1;
        load_addr    = 2;
        load_data    = new_d;
        load_type    = new_t;
        tick();
        data_request = 1'b0;
        load_valid   = 1'b0;
        m_data[2] = new_d;
        m_type[2] = new_t;
        tick();
        tick();
        checks++;
        if (read_done !== 1'b1 || training_data !== old_d || training_data_type !== old_t) begin
            errors++;
            $display("FAIL collision_old: got rd %b type %0d want 1 type %0d old data",
                     read_done, training_data_type, old_t);
        end
        model_serve();
        tick();
        do_rewind();
        for (int i = 0; i < 3; i++) fetch_check($sformatf("coll_pass2_%0d", i));
        checks++;
        if (training_data !== new_d || training_data_type !== new_t) begin
            errors++;
            $display("FAIL collision_new: got type %0d want %0d", training_data_type, new_t);
        end
    endtask

    task automatic test_input_load();
        for (int i = 0; i < 6; i++) begin
            input_vec  = rand_vec();
            input_load = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (input_load) m_query = input_vec;
            tick();
            input_load = 1'b0;
            checks++;
            if (input_data !== m_query) begin
                errors++;
                $display("FAIL input_load %0d: got %h want %h", i, input_data[63:0], m_query[63:0]);
            end
        end
    endtask

    task automatic test_midflight_reset();
        fetch_check("pre_reset");
        data_request = 1'b1;
        tick();
        data_request = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_idx   = 0;
        m_exh   = 1'b0;
        m_query = '0;
        checks++;
        if (read_done !== 1'b0 || busy !== 1'b0 || vector_index !== '0
            || training_data !== '0 || input_data !== '0) begin
            errors++;
            $display("FAIL midflight_reset: got rd %b busy %b idx %0d want 0 0 0 and zero data",
                     read_done, busy, vector_index);
        end
        tick();
        checks++;
        if (read_done !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset_late: got read_done %b want 0", read_done);
        end
        fetch_check("mem_kept_after_reset");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_entry5();
        test_back_to_back();
        test_rewind_in_read();
        test_load_collision();
        test_input_load();
        test_midflight_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/training_data_feeder.md
TRAINING_DATA_FEEDER -- requirements
Module: training_data_feeder

Interface
REQ-001 SHALL have parameter W, default 16, meaning bits per feature element.
REQ-002 SHALL have parameter MAX_ELEMENTS, default 32, meaning feature elements per vector.
REQ-003 SHALL have parameter TYPE_W, default 3, meaning class-label width.
REQ-004 SHALL have parameter L, default 6, meaning log2 of stored training vectors (NV = 1<<L).
REQ-005 SHALL have port clk, input, 1, meaning single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have port load_valid, input, 1, meaning write one training entry this cycle.
REQ-008 SHALL have port load_addr, input, L, meaning entry index to write.
REQ-009 SHALL have port load_data, input, W*MAX_ELEMENTS, meaning training vector to write.
REQ-010 SHALL have port load_type, input, TYPE_W, meaning label to write.
REQ-011 SHALL have port input_load, input, 1, meaning capture input_vec into the query register.
REQ-012 SHALL have port input_vec, input, W*MAX_ELEMENTS, meaning query vector.
REQ-013 SHALL have port rewind, input, 1, meaning return to entry 0 and clear exhaustion.
REQ-014 SHALL have port data_request, input, 1, meaning consumer asks for the next training entry.
REQ-015 SHALL have port training_data, output, W*MAX_ELEMENTS, meaning presented training vector.
REQ-016 SHALL have port training_data_type, output, TYPE_W, meaning presented label.
REQ-017 SHALL have port input_data, output, W*MAX_ELEMENTS, meaning held query vector.
REQ-018 SHALL have port read_done, output, 1, meaning one-cycle pulse: presented entry valid.
REQ-019 SHALL have port vector_index, output, L, meaning index of the next entry to serve.
REQ-020 SHALL have port set_done, output, 1, meaning one-cycle pulse coincident with read_done of entry NV-1.
REQ-021 SHALL have port exhausted, output, 1, meaning all NV entries served, no wrap.
REQ-022 SHALL have port busy, output, 1, meaning FSM is not in IDLE.

Function
REQ-023 SHALL implement FSM states IDLE, READ, PRESENT, EXHAUSTED.
REQ-024 SHALL, in IDLE with data_request=1, issue a memory read at vector_index and go to READ.
REQ-025 SHALL go READ->PRESENT unconditionally; PRESENT registers mem data to training_data/training_data_type and pulses read_done.
REQ-026 SHALL give a latency of exactly 2 cycles from the data_request sample edge to the read_done=1 cycle.
REQ-027 SHALL hold training_data/training_data_type stable from read_done until the next read_done.
REQ-028 SHALL ignore data_request outside IDLE, with no queuing.
REQ-029 SHALL keep data_request held high after PRESENT returns to IDLE, so the next fetch starts in the IDLE cycle.
REQ-030 SHALL increment vector_index at the PRESENT cycle, modulo NV.
REQ-031 SHALL pulse set_done when the PRESENT-cycle index equals NV-1.
REQ-032 SHALL accept load_valid in any state with read-first semantics: a read and a write to the same address in one cycle returns the old data.
REQ-033 SHALL update input_data the cycle after input_load=1, independent of FSM state.
REQ-034 SHALL, on rewind (any state), set vector_index=0, exhausted=0, state=IDLE, abort any fetch in flight (no read_done), and take priority over a simultaneous data_request.

Reset
REQ-035 SHALL, on rst, set state=IDLE, vector_index=0, read_done=0, set_done=0, exhausted=0, busy=0, training_data=0, training_data_type=0, input_data=0.
REQ-036 SHALL leave memory contents unchanged by rst.
REQ-037 SHALL abort an in-flight fetch on rst mid-operation, with no read_done.

Configuration
REQ-038 SHALL, with KNN_FEEDER_WRAP_EN defined, return to IDLE after entry NV-1 with index 0, keep exhausted=0 and keep serving.
REQ-039 SHALL, without KNN_FEEDER_WRAP_EN, go PRESENT->EXHAUSTED after entry NV-1, set exhausted=1, ignore data_request, and leave only via rewind or rst.

Structure
REQ-040 SHALL take W, MAX_ELEMENTS, TYPE_W, L and the FSM state encoding from shared package knn_pkg, also used by knn_system.
REQ-041 SHALL place storage in one sub-module, training_mem: NV x (W*MAX_ELEMENTS+TYPE_W), one synchronous write port, one registered read port, read-first.

Verification
REQ-042 SHALL cover: load entry 5 = data 0x0A.., type 3; rewind; 6 requests -> sixth read_done shows type 3, vector_index=6 after.
REQ-043 SHALL cover: data_request held high continuously -> read_done every 3 cycles, index 0..NV-1 in order.
REQ-044 SHALL cover: 64 requests without WRAP_EN -> set_done with 64th read_done, exhausted=1, 65th request gives no read_done; rewind -> exhausted=0.
REQ-045 SHALL cover: 64 requests with WRAP_EN -> set_done on 64th, 65th read_done serves entry 0.
REQ-046 SHALL cover: rewind in READ cycle -> no read_done, vector_index=0, busy=0 next cycle.
REQ-047 SHALL cover: load to addr 2 in the same cycle as the read of addr 2 -> old value presented, new value on next pass.
